store_buffer: RTL and testbench

- Sits directly upstream of the unified memory's port 0 (the r/w port); port 1 stays dedicated to instruction fetch.
- Queues pipeline stores in a FIFO and drains them into memory one per cycle when port 0 is not needed for a load.
- Lets the MEM stage retire a store in one cycle.
- Keeps loads coherent by stalling any load that overlaps a pending store.

---
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: FIFO of pending pipeline stores placed in front of memory
// port 0. Stores retire into the buffer in one cycle and drain to memory
// whenever port 0 is not claimed by a load. Loads whose word footprint
// overlaps any buffered store are stalled until those entries drain.
//
// Handshake: a store transfers on a cycle where st_valid & st_ready are both
// high at the rising edge of clk (size 11 is dropped without being queued).
// st_ready never depends on st_valid. A load is serviced in the cycle where
// ld_valid is high and ld_stall is low; while stalled, the pipeline holds
// ld_* stable.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [1:0]       st_size,
  input  logic [31:0]      st_data,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [1:0]       ld_size,
  output logic [31:0]      ld_data,
  output logic             ld_stall,
  input  logic             drain_req,
  output logic             sb_empty,
  output logic [PTR_W:0]   sb_count,
  output logic             r_w_0,
  output logic [1:0]       mem_size0,
  output logic [31:0]      mem_addr0,
  output logic [31:0]      mem_in0,
  input  logic [31:0]      mem_out0
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      ent_addr [DEPTH];
  logic [1:0]       ent_size [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [29:0] ld_idx;
  logic        conflict;
  logic        grant_ld;
  logic        do_drain;
  logic        enq;

  assign ld_idx   = ld_addr[31:2];
  assign st_ready = (count < CNT_FULL) & ~drain_req;
  assign enq      = st_valid & st_ready & (st_size != 2'b11);
  assign grant_ld = ld_valid & ~conflict & ~st_valid;
  assign do_drain = ~grant_ld & (count != '0);
  assign sb_empty = (count == '0);
  assign sb_count = count;

  // Conservative overlap: each access may touch its word and the next one,
  // so two accesses collide when their {idx, idx+1} pairs share a word.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] &&
          ((ent_addr[i][31:2] == ld_idx) ||
           (ent_addr[i][31:2] == ld_idx + 30'd1) ||
           (ent_addr[i][31:2] + 30'd1 == ld_idx)))
        conflict = 1'b1;
    end
  end

  // Port 0 arbitration: a clean load wins, otherwise the head store drains.
  always_comb begin
    r_w_0     = 1'b0;
    mem_addr0 = '0;
    mem_size0 = '0;
    mem_in0   = '0;
    ld_data   = '0;
    ld_stall  = ld_valid;
    if (grant_ld) begin
      mem_addr0 = ld_addr;
      mem_size0 = ld_size;
      ld_data   = mem_out0;
      ld_stall  = 1'b0;
    end else if (count != '0) begin
      r_w_0     = 1'b1;
      mem_addr0 = ent_addr[head];
      mem_size0 = ent_size[head];
      mem_in0   = ent_data[head];
    end
  end

  // Pointers, occupancy and valid bits; reset discards every pending store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_ONE;
      end
      if (do_drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_ONE;
      end
      case ({enq, do_drain})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry payload is qualified by ent_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= st_addr;
      ent_size[tail] <= st_size;
      ent_data[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios followed by randomized traffic. A
// reference model (queue of pending stores plus a byte-array architectural
// memory) predicts every control output, every memory write and every load
// result.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             st_valid = 1'b0;
  logic             st_ready;
  logic [31:0]      st_addr = '0;
  logic [1:0]       st_size = '0;
  logic [31:0]      st_data = '0;
  logic             ld_valid = 1'b0;
  logic [31:0]      ld_addr = '0;
  logic [1:0]       ld_size = '0;
  logic [31:0]      ld_data;
  logic             ld_stall;
  logic             drain_req = 1'b0;
  logic             sb_empty;
  logic [PTR_W:0]   sb_count;
  logic             r_w_0;
  logic [1:0]       mem_size0;
  logic [31:0]      mem_addr0;
  logic [31:0]      mem_in0;
  logic [31:0]      mem_out0;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_size(st_size), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_data(ld_data), .ld_stall(ld_stall),
    .drain_req(drain_req), .sb_empty(sb_empty), .sb_count(sb_count),
    .r_w_0(r_w_0), .mem_size0(mem_size0), .mem_addr0(mem_addr0),
    .mem_in0(mem_in0), .mem_out0(mem_out0)
  );

  // ---------------- memory attached to port 0 ----------------
  logic [7:0]  dmem [0:4095] = '{default: 8'h00};
  logic [11:0] ma;
  logic [31:0] raw;
  assign ma  = mem_addr0[11:0];
  assign raw = {dmem[ma + 12'd3], dmem[ma + 12'd2], dmem[ma + 12'd1], dmem[ma]};
  assign mem_out0 = (mem_size0 == 2'b00) ? {24'h0, raw[7:0]} :
                    (mem_size0 == 2'b01) ? {16'h0, raw[15:0]} : raw;

  always @(posedge clk) begin
    if (!reset && r_w_0) begin
      dmem[ma] <= mem_in0[7:0];
      if (mem_size0 != 2'b00) dmem[ma + 12'd1] <= mem_in0[15:8];
      if (mem_size0 == 2'b10) begin
        dmem[ma + 12'd2] <= mem_in0[23:16];
        dmem[ma + 12'd3] <= mem_in0[31:24];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } st_t;

  st_t         mq[$];        // stores accepted but not yet written
  logic [65:0] exp_q[$];     // expected memory writes, in program order
  logic [7:0]  rmem [0:4095] = '{default: 8'h00};

  int tests = 0;
  int fails = 0;
  logic ld_was_stalled = 1'b0;
  logic st_was_ready = 1'b1;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Two accesses overlap if any word either may touch is shared.
  function automatic logic overlap(input logic [31:0] a, input logic [31:0] b);
    logic [29:0] wa [2];
    logic [29:0] wb [2];
    wa[0] = a[31:2]; wa[1] = a[31:2] + 30'd1;
    wb[0] = b[31:2]; wb[1] = b[31:2] + 30'd1;
    foreach (wa[i]) foreach (wb[j]) if (wa[i] == wb[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v = '0;
    for (int k = 0; k < nbytes(s); k++) v[8*k +: 8] = rmem[12'(a + 32'(k))];
    return v;
  endfunction

  task automatic ref_write(input st_t s);
    for (int k = 0; k < nbytes(s.size); k++) rmem[12'(s.addr + 32'(k))] = s.data[8*k +: 8];
  endtask

  // Monitor: predicts this cycle's outputs from the model, then advances it.
  logic m_conf, m_grant, m_drain, m_rdy;
  logic [65:0] m_exp;
  always @(negedge clk) begin
    if (!reset) begin
      m_conf = 1'b0;
      foreach (mq[i]) if (overlap(mq[i].addr, ld_addr)) m_conf = 1'b1;
      m_grant = ld_valid && !m_conf && !st_valid;
      m_drain = !m_grant && (mq.size() > 0);
      m_rdy   = (mq.size() < DEPTH) && !drain_req;

      check("st_ready", 66'(st_ready), 66'(m_rdy));
      check("sb_count", 66'(sb_count), 66'(mq.size()));
      check("sb_empty", 66'(sb_empty), 66'(mq.size() == 0));
      check("ld_stall", 66'(ld_stall), 66'(ld_valid && !m_grant));
      check("r_w_0", 66'(r_w_0), 66'(m_drain));
      if (m_grant) begin
        check("ld_mem_addr", 66'(mem_addr0), 66'(ld_addr));
        check("ld_data", 66'(ld_data), 66'(ref_read(ld_addr, ld_size)));
      end
      if (r_w_0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 66'({mem_addr0, mem_size0, mem_in0}), 66'h0);
        end else begin
          m_exp = exp_q.pop_front();
          check("write", {mem_addr0, mem_size0, mem_in0}, m_exp);
        end
      end

      if (m_drain) ref_write(mq.pop_front());
      if (st_valid && m_rdy && st_size != 2'b11) begin
        mq.push_back('{addr: st_addr, size: st_size, data: st_data});
        exp_q.push_back({st_addr, st_size, st_data});
      end
      ld_was_stalled = ld_stall;
      st_was_ready   = st_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    st_valid = v; st_addr = a; st_size = s; st_data = d;
  endtask

  task automatic set_ld(input logic v, input logic [31:0] a, input logic [1:0] s);
    ld_valid = v; ld_addr = a; ld_size = s;
  endtask

  task automatic idle();
    set_st(1'b0, 32'h0, 2'b00, 32'h0);
    set_ld(1'b0, 32'h0, 2'b00);
    drain_req = 1'b0;
  endtask

  // Fill n entries by alternating a store with a non-conflicting load.
  task automatic fill(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      set_ld(1'b0, 32'h0, 2'b00);
      set_st(1'b1, base + 32'(4 * k), 2'b10, $urandom);
      tick();
      set_st(1'b0, 32'h0, 2'b00, 32'h0);
      set_ld(1'b1, 32'h400, 2'b10);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_st_ready", 66'(st_ready), 66'(1));
    check("rst_sb_empty", 66'(sb_empty), 66'(1));
    check("rst_sb_count", 66'(sb_count), 66'(0));
    check("rst_r_w_0", 66'(r_w_0), 66'(0));
    check("rst_mem_addr0", 66'(mem_addr0), 66'(0));
    check("rst_mem_in0", 66'(mem_in0), 66'(0));
    check("rst_mem_size0", 66'(mem_size0), 66'(0));
    check("rst_ld_stall", 66'(ld_stall), 66'(0));
    reset = 1'b0;
    tick();

    // Single word store, then read it back.
    set_st(1'b1, 32'h100, 2'b10, 32'hDEADBEEF); tick();
    idle(); tick(); tick();
    set_ld(1'b1, 32'h100, 2'b10); tick();
    idle(); tick();

    // Byte store followed by an overlapping word load.
    set_st(1'b1, 32'h203, 2'b00, 32'h000000AA); tick();
    set_st(1'b0, 32'h0, 2'b00, 32'h0);
    set_ld(1'b1, 32'h200, 2'b10); tick(); tick();
    idle(); tick();

    // Fill to DEPTH, try a store while full, then drain in order.
    fill(DEPTH, 32'h10);
    set_ld(1'b0, 32'h0, 2'b00);
    set_st(1'b1, 32'h500, 2'b10, 32'h55AA55AA); tick();
    idle(); repeat (6) tick();

    // Unaligned word store: far load granted, idx+1 overlap stalls.
    set_st(1'b1, 32'h32, 2'b10, 32'h11223344); tick();
    set_st(1'b0, 32'h0, 2'b00, 32'h0);
    set_ld(1'b1, 32'h40, 2'b10); tick();
    set_ld(1'b1, 32'h35, 2'b10); tick(); tick();
    idle(); tick();

    // Fence: no enqueue while draining to empty.
    fill(2, 32'h600);
    set_ld(1'b0, 32'h0, 2'b00);
    drain_req = 1'b1;
    set_st(1'b1, 32'h700, 2'b10, 32'h0BADF00D);
    repeat (3) tick();
    idle(); tick();

    // Reset in the middle of draining three entries.
    fill(3, 32'h800);
    idle(); tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_sb_count", 66'(sb_count), 66'(0));
    check("midrst_sb_empty", 66'(sb_empty), 66'(1));
    check("midrst_r_w_0", 66'(r_w_0), 66'(0));
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) tick();

    // Randomized traffic around a small address window to force conflicts.
    for (int n = 0; n < 3000; n++) begin
      if (!(ld_valid && ld_was_stalled)) begin
        set_ld($urandom_range(0, 99) < 50, 32'($urandom_range(0, 127)), 2'($urandom_range(0, 2)));
      end
      if (!(st_valid && !st_was_ready)) begin
        set_st($urandom_range(0, 99) < 45, 32'($urandom_range(0, 127)),
               2'($urandom_range(0, 3)), $urandom);
      end
      if (drain_req) drain_req = ($urandom_range(0, 99) >= 10);
      else           drain_req = ($urandom_range(0, 99) < 3);
      tick();
    end

    // Let everything drain and confirm nothing is left outstanding.
    idle();
    for (int n = 0; n < 40 && !sb_empty; n++) tick();
    tick();
    check("final_empty", 66'(sb_empty), 66'(1));
    check("final_exp_q", 66'(exp_q.size()), 66'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
